// File: rtl/alu_op_sequencer.sv
// Pushbutton + switch command front end for the a/b inc/dec ALU:
// sync, debounce, opcode screen, command FIFO with valid/ready output.
module alu_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int OP_W            = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn,
  input  logic [OP_W-1:0] sw,
  input  logic            op_ready,
  output logic [OP_W-1:0] op,
  output logic            en,
  output logic            fifo_full,
  output logic            bad_op,
  output logic [7:0]      drop_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  logic            r_btn_m, r_btn_s;
  logic [OP_W-1:0] r_sw_m, r_sw_s;
  logic            r_btn_db, r_btn_db_q;
  logic [CW-1:0]   r_db_cnt;
  logic            r_cmd_vld;
  logic [OP_W-1:0] r_cmd_op;
  logic            r_bad_op;
  logic [OP_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PW:0]     r_count;
  logic [7:0]      r_drop_cnt;

  logic w_press, w_legal, w_push, w_pop;
  logic w_accept, w_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_m    <= 1'b0;
      r_btn_s    <= 1'b0;
      r_sw_m     <= '0;
      r_sw_s     <= '0;
      r_btn_db   <= 1'b0;
      r_btn_db_q <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_btn_m    <= btn;
      r_btn_s    <= r_btn_m;
      r_sw_m     <= sw;
      r_sw_s     <= r_sw_m;
      r_btn_db_q <= r_btn_db;
      // Count consecutive cycles the synced input disagrees with db
      if (r_btn_s != r_btn_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_btn_db <= r_btn_s;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + CW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_press = r_btn_db & ~r_btn_db_q;

  always_comb begin
    w_legal = 1'b0;
    case (r_sw_s)
      OP_W'(8'h71), OP_W'(8'h72),
      OP_W'(8'h76), OP_W'(8'h77),
      OP_W'(8'h79), OP_W'(8'h7A),
      OP_W'(8'h7E), OP_W'(8'h7F):
        w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_vld <= 1'b0;
      r_cmd_op  <= '0;
      r_bad_op  <= 1'b0;
    end else begin
      r_cmd_vld <= w_press & w_legal;
      r_cmd_op  <= r_sw_s;
      r_bad_op  <= w_press & ~w_legal;
    end
  end

  assign en        = (r_count != '0);
  assign fifo_full = (r_count == DEPTH_C);
  assign w_push    = r_cmd_vld;
  assign w_pop     = en & op_ready;
  // A pop in the same cycle frees the slot for a push into a full queue
  assign w_accept  = w_push & (~fifo_full | w_pop);
  assign w_drop    = w_push & fifo_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= r_cmd_op;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign op       = en ? r_mem[r_rd_ptr] : '0;
  assign bad_op   = r_bad_op;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table of opcodes
// plus hand sequences for latency, glitch, backpressure and reset.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [7:0] sw;
  logic       op_ready;
  logic [7:0] op;
  logic       en;
  logic       fifo_full;
  logic       bad_op;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  int bad_n = 0;

  typedef struct {
    logic [7:0] sw;
    logic       legal;
  } vec_t;

  vec_t tbl[12];

  alu_op_sequencer dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .sw(sw),
    .op_ready(op_ready),
    .op(op),
    .en(en),
    .fifo_full(fifo_full),
    .bad_op(bad_op),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Transfers and bad_op pulses as seen just before each rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (en && op_ready) q.push_back(op);
      if (bad_op) bad_n = bad_n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] code, input int hold);
    sw = code;
    cyc(3);
    btn = 1'b1;
    cyc(hold);
    btn = 1'b0;
    cyc(12);
  endtask

  initial begin
    int base;
    int bbase;
    logic pre_ok;

    tbl[0]  = '{8'h71, 1'b1};
    tbl[1]  = '{8'h72, 1'b1};
    tbl[2]  = '{8'h76, 1'b1};
    tbl[3]  = '{8'h77, 1'b1};
    tbl[4]  = '{8'h79, 1'b1};
    tbl[5]  = '{8'h7A, 1'b1};
    tbl[6]  = '{8'h7E, 1'b1};
    tbl[7]  = '{8'h7F, 1'b1};
    tbl[8]  = '{8'h00, 1'b0};
    tbl[9]  = '{8'h73, 1'b0};
    tbl[10] = '{8'h7D, 1'b0};
    tbl[11] = '{8'hF1, 1'b0};

    rst = 1'b1;
    btn = 1'b0;
    sw = 8'h00;
    op_ready = 1'b0;
    cyc(3);
    chk("rst_en", en, 0);
    chk("rst_op", op, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_bad", bad_op, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    cyc(2);

    // Latency: en must rise after edge N+7 and last one cycle
    op_ready = 1'b1;
    sw = 8'h72;
    cyc(3);
    btn = 1'b1;
    cyc(1);
    pre_ok = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      if (en) pre_ok = 1'b0;
    end
    chk("lat_early_en", pre_ok, 1);
    cyc(1);
    chk("lat_en", en, 1);
    chk("lat_op", op, 8'h72);
    cyc(1);
    chk("lat_one_cycle", en, 0);
    cyc(2);
    btn = 1'b0;
    cyc(12);

    // Glitch of 3 cycles
    base = q.size();
    bbase = bad_n;
    sw = 8'h71;
    press(8'h71, 3);
    chk("glitch_en", q.size() - base, 0);
    chk("glitch_bad", bad_n - bbase, 0);

    foreach (tbl[i]) begin
      base = q.size();
      bbase = bad_n;
      press(tbl[i].sw, 6);
      chk($sformatf("vec%0d_cnt", i), q.size() - base,
          tbl[i].legal ? 1 : 0);
      if (tbl[i].legal)
        chk($sformatf("vec%0d_op", i), q[base], tbl[i].sw);
      chk($sformatf("vec%0d_bad", i), bad_n - bbase,
          tbl[i].legal ? 0 : 1);
    end
    chk("vec_drop", drop_cnt, 0);

    // Backpressure: 6 presses into a 4-deep queue
    op_ready = 1'b0;
    base = q.size();
    press(8'h71, 6);
    press(8'h76, 6);
    press(8'h79, 6);
    press(8'h7E, 6);
    press(8'h77, 6);
    press(8'h7A, 6);
    chk("bp_full", fifo_full, 1);
    chk("bp_drop", drop_cnt, 2);
    chk("bp_head", op, 8'h71);
    cyc(3);
    chk("bp_stable_op", op, 8'h71);
    chk("bp_stable_en", en, 1);
    op_ready = 1'b1;
    cyc(8);
    chk("bp_cnt", q.size() - base, 4);
    chk("bp_q0", q[base], 8'h71);
    chk("bp_q1", q[base+1], 8'h76);
    chk("bp_q2", q[base+2], 8'h79);
    chk("bp_q3", q[base+3], 8'h7E);
    chk("bp_empty", en, 0);

    // Reset with 3 entries queued
    op_ready = 1'b0;
    press(8'h7F, 6);
    press(8'h7A, 6);
    press(8'h77, 6);
    chk("pre_rst_en", en, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_en", en, 0);
    chk("mid_rst_op", op, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_full", fifo_full, 0);
    cyc(2);
    rst = 1'b0;
    base = q.size();
    op_ready = 1'b1;
    cyc(20);
    chk("post_rst_none", q.size() - base, 0);

    // Full queue plus a push that coincides with a pop
    op_ready = 1'b0;
    base = q.size();
    press(8'h71, 6);
    press(8'h76, 6);
    press(8'h79, 6);
    press(8'h7E, 6);
    chk("fp_full_pre", fifo_full, 1);
    sw = 8'h7F;
    cyc(3);
    btn = 1'b1;
    cyc(1);
    cyc(6);
    op_ready = 1'b1;
    cyc(1);
    op_ready = 1'b0;
    chk("fp_full", fifo_full, 1);
    chk("fp_drop", drop_cnt, 0);
    chk("fp_head", op, 8'h76);
    cyc(3);
    btn = 1'b0;
    cyc(12);
    op_ready = 1'b1;
    cyc(10);
    chk("fp_cnt", q.size() - base, 5);
    chk("fp_q0", q[base], 8'h71);
    chk("fp_q1", q[base+1], 8'h76);
    chk("fp_q2", q[base+2], 8'h79);
    chk("fp_q3", q[base+3], 8'h7E);
    chk("fp_q4", q[base+4], 8'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
